// File: rtl/spike_event_scheduler.sv
// rtl/spike_event_scheduler.sv - round-robin spike intake, event FIFO and neuron update/accumulate sweep sequencer
module spike_event_scheduler #(
  parameter int N_NEURONS  = 16,
  parameter int SYN_W      = 14,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TIME_W     = 16,
  localparam int NW        = $clog2(N_NEURONS),
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CNTW      = AW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [TIME_W-1:0]        run_steps,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*SYN_W-1:0]  in_index,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [NW-1:0]            c_neuron_index,
  output logic [SYN_W-1:0]         c_synapse_index,
  output logic                     c_neuron_we,
  output logic                     c_accumulate,
  output logic [TIME_W-1:0]        network_time,
  output logic [CNTW-1:0]          fifo_count,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_ACCUM} state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       idx_q, idx_d;
  logic                phase_q, phase_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic [TIME_W-1:0]   steps_q, steps_d;
  logic                stop_q, stop_d;
  logic                done_q, done_d;
  logic [SYN_W-1:0]    syn_q, syn_d;
  logic [CW-1:0]       rr_q, rr_d;

  logic [SYN_W-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic                fifo_full, fifo_empty, push, pop;
  logic                grant_vld;
  logic [CW-1:0]       grant_ch;
  logic [CW:0]         cand;
  logic [SYN_W-1:0]    grant_data;
  logic [TIME_W-1:0]   time_inc;
  logic                last_idx, end_run;

  assign fifo_full  = (cnt_q == CNTW'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign time_inc   = time_q + TIME_W'(1);
  assign last_idx   = (idx_q == NW'(N_NEURONS - 1));

  // Round-robin search from the priority pointer; space is judged on the registered count only
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_q} + (CW+1)'(i);
      if (cand >= (CW+1)'(NUM_CH)) cand = cand - (CW+1)'(NUM_CH);
      if (!grant_vld && !fifo_full && !reset && in_valid[cand[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = cand[CW-1:0];
      end
    end
  end

  // One-hot ready, pushed index and next priority pointer
  always_comb begin
    in_ready   = '0;
    grant_data = in_index[int'(grant_ch)*SYN_W +: SYN_W];
    rr_d       = rr_q;
    if (grant_vld) begin
      in_ready[grant_ch] = 1'b1;
      rr_d = (grant_ch == CW'(NUM_CH - 1)) ? '0 : grant_ch + CW'(1);
    end
  end

  assign push = grant_vld;

  // FIFO occupancy: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
    else if (!push && pop) cnt_d = cnt_q - CNTW'(1);
  end

  // Run end is decided at the sweep boundary: run length only counts update sweeps
  assign end_run = (state_q == S_UPDATE) ? (((steps_q != '0) && (time_inc == steps_q)) || stop_q)
                                         : stop_q;

  // Sweep sequencer: two cycles per neuron, decisions only at the sweep boundary
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    time_d  = time_q;
    steps_d = steps_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    syn_d   = syn_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          time_d  = '0;
          steps_d = run_steps;
          idx_d   = '0;
          phase_d = 1'b0;
          state_d = S_UPDATE;
        end
      end
      default: begin
        stop_d  = stop_q | stop;
        phase_d = ~phase_q;
        if (phase_q) begin
          if (!last_idx) begin
            idx_d = idx_q + NW'(1);
          end else begin
            idx_d = '0;
            if (state_q == S_UPDATE) time_d = time_inc;
            if (end_run) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end else if (!fifo_empty) begin
              pop     = 1'b1;
              syn_d   = mem_q[rd_q];
              state_d = S_ACCUM;
            end else begin
              state_d = S_UPDATE;
            end
          end
        end
      end
    endcase
  end

  // Control and FIFO pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      phase_q <= 1'b0;
      time_q  <= '0;
      steps_q <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      syn_q   <= '0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      time_q  <= time_d;
      steps_q <= steps_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
      syn_q   <= syn_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
    end
  end

  // Event storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= grant_data;
  end

  assign busy            = (state_q != S_IDLE);
  assign c_neuron_we     = busy & phase_q;
  assign c_neuron_index  = idx_q;
  assign c_accumulate    = (state_q == S_ACCUM);
  assign c_synapse_index = syn_q;
  assign network_time    = time_q;
  assign fifo_count      = cnt_q;
  assign done            = done_q;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// tb/tb_spike_event_scheduler.sv - randomized bench for spike_event_scheduler against a sweep-level reference model
module tb_spike_event_scheduler;

  localparam int N   = 4;
  localparam int SW  = 14;
  localparam int NCH = 4;
  localparam int DEP = 8;
  localparam int TW  = 4;

  logic            clk = 1'b0;
  logic            reset, start, stop;
  logic [TW-1:0]   run_steps;
  logic [NCH-1:0]  in_valid, in_ready;
  logic [NCH*SW-1:0] in_index;
  logic [1:0]      c_neuron_index;
  logic [SW-1:0]   c_synapse_index;
  logic            c_neuron_we, c_accumulate, busy, done;
  logic [TW-1:0]   network_time;
  logic [3:0]      fifo_count;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: one cycle counter per sweep instead of index/phase registers
  bit  m_busy, m_acc, m_stop, m_done;
  int  m_k, m_time, m_steps, m_syn, m_ptr;
  int  m_q[$];

  // per-channel spike sources that hold an event until accepted
  int  src_buf[NCH][64];
  int  src_hd[NCH];
  int  src_tl[NCH];

  spike_event_scheduler #(.N_NEURONS(N), .SYN_W(SW), .NUM_CH(NCH), .FIFO_DEPTH(DEP), .TIME_W(TW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .run_steps(run_steps),
    .in_valid(in_valid), .in_index(in_index), .in_ready(in_ready),
    .c_neuron_index(c_neuron_index), .c_synapse_index(c_synapse_index),
    .c_neuron_we(c_neuron_we), .c_accumulate(c_accumulate),
    .network_time(network_time), .fifo_count(fifo_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] exp_ready();
    logic [NCH-1:0] r;
    bit found;
    r = '0;
    found = 0;
    if (m_q.size() < DEP)
      for (int i = 0; i < NCH; i++)
        if (!found && in_valid[(m_ptr + i) % NCH]) begin
          r[(m_ptr + i) % NCH] = 1'b1;
          found = 1;
        end
    return r;
  endfunction

  function automatic int exp_index();
    return m_k / 2;
  endfunction

  function automatic bit exp_we();
    return m_busy && (m_k % 2 == 1);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_stop = 0; m_done = 0;
    m_k = 0; m_time = 0; m_steps = 0; m_syn = 0; m_ptr = 0;
    m_q.delete();
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NCH; c++) begin
      in_valid[c] = (src_tl[c] != src_hd[c]);
      in_index[c*SW +: SW] = SW'(src_buf[c][src_hd[c] % 64]);
    end
    #1;
  endtask

  task automatic src_push(input int ch, input int val);
    src_buf[ch][src_tl[ch] % 64] = val;
    src_tl[ch]++;
  endtask

  task automatic model_step(input int gc);
    bit stop_old, fin;
    int pv;
    m_done = 0;
    pv = (gc >= 0) ? src_buf[gc][src_hd[gc] % 64] : 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_acc = 0; m_k = 0; m_time = 0; m_steps = int'(run_steps); m_stop = 0;
      end
    end else begin
      stop_old = m_stop;
      if (stop) m_stop = 1;
      if (m_k != 2*N - 1) m_k++;
      else begin
        m_k = 0;
        if (!m_acc) begin
          m_time = (m_time + 1) % (1 << TW);
          fin = ((m_steps != 0) && (m_time == m_steps)) || stop_old;
        end else fin = stop_old;
        if (fin) begin
          m_busy = 0; m_acc = 0; m_stop = 0; m_done = 1;
        end else if (m_q.size() > 0) begin
          m_syn = m_q.pop_front(); m_acc = 1;
        end else m_acc = 0;
      end
    end
    if (gc >= 0) begin
      m_q.push_back(pv);
      m_ptr = (gc + 1) % NCH;
    end
  endtask

  task automatic cycle();
    logic [NCH-1:0] g;
    int gc;
    g = exp_ready();
    gc = -1;
    for (int c = 0; c < NCH; c++) if (g[c]) gc = c;
    model_step(gc);
    @(posedge clk);
    #1;
    start = 0;
    stop = 0;
    if (gc >= 0) src_hd[gc]++;
    drive_inputs();
  endtask

  task automatic hard_reset();
    reset = 1; start = 0; stop = 0; run_steps = '0;
    for (int c = 0; c < NCH; c++) begin src_hd[c] = 0; src_tl[c] = 0; end
    drive_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    drive_inputs();
  endtask

  task automatic test_reset();
    reset = 1; start = 0; stop = 0; run_steps = '0;
    for (int c = 0; c < NCH; c++) begin src_hd[c] = 0; src_tl[c] = 0; src_push(c, 100 + c); end
    drive_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0d want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0d want 0", done); end
    n_vec++; if (network_time !== '0) begin n_err++; $display("FAIL reset_time got %0d want 0", network_time); end
    n_vec++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_vec++; if (in_ready !== '0) begin n_err++; $display("FAIL reset_ready got %b want 0000", in_ready); end
    n_vec++; if ({c_neuron_index, c_neuron_we, c_accumulate, c_synapse_index} !== '0) begin
      n_err++; $display("FAIL reset_ctrl got idx=%0d we=%0d acc=%0d syn=%0h want all 0",
                        c_neuron_index, c_neuron_we, c_accumulate, c_synapse_index);
    end
    hard_reset();
  endtask

  task automatic test_run_length();
    int busy_cnt, done_cnt;
    hard_reset();
    busy_cnt = 0; done_cnt = 0;
    run_steps = 4'd3; start = 1;
    cycle();
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL run_busy cyc %0d got %0d want %0d", i, busy, m_busy); end
      n_vec++; if (c_neuron_we !== exp_we()) begin n_err++; $display("FAIL run_we cyc %0d got %0d want %0d", i, c_neuron_we, exp_we()); end
      n_vec++; if (int'(c_neuron_index) != exp_index()) begin n_err++; $display("FAIL run_index cyc %0d got %0d want %0d", i, c_neuron_index, exp_index()); end
      n_vec++; if (int'(network_time) != m_time) begin n_err++; $display("FAIL run_time cyc %0d got %0d want %0d", i, network_time, m_time); end
      n_vec++; if (done !== m_done) begin n_err++; $display("FAIL run_done cyc %0d got %0d want %0d", i, done, m_done); end
      cycle();
    end
    n_vec++; if (busy_cnt != 24) begin n_err++; $display("FAIL run_busy_len got %0d want 24", busy_cnt); end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL run_done_pulses got %0d want 1", done_cnt); end
    n_vec++; if (network_time !== 4'd3) begin n_err++; $display("FAIL run_final_time got %0d want 3", network_time); end
  endtask

  task automatic test_accum_order();
    int hits;
    hard_reset();
    hits = 0;
    run_steps = 4'd4; start = 1;
    cycle();
    for (int i = 0; i < 45; i++) begin
      if (i == 3) begin src_push(2, 'h155); drive_inputs(); end
      if (c_accumulate && c_synapse_index == 14'h155) begin
        hits++;
        n_vec++; if (network_time !== 4'd1) begin n_err++; $display("FAIL acc_time_frozen got %0d want 1", network_time); end
      end
      n_vec++; if (c_accumulate !== (m_busy && m_acc)) begin n_err++; $display("FAIL acc_flag cyc %0d got %0d want %0d", i, c_accumulate, m_busy && m_acc); end
      n_vec++; if (int'(c_synapse_index) != m_syn) begin n_err++; $display("FAIL acc_syn cyc %0d got %0h want %0h", i, c_synapse_index, m_syn); end
      n_vec++; if (int'(fifo_count) != m_q.size()) begin n_err++; $display("FAIL acc_count cyc %0d got %0d want %0d", i, fifo_count, m_q.size()); end
      n_vec++; if (int'(network_time) != m_time) begin n_err++; $display("FAIL acc_time cyc %0d got %0d want %0d", i, network_time, m_time); end
      cycle();
    end
    n_vec++; if (hits != 8) begin n_err++; $display("FAIL acc_sweep_len got %0d want 8", hits); end
    n_vec++; if (network_time !== 4'd4 || busy !== 1'b0) begin n_err++; $display("FAIL acc_end got time=%0d busy=%0d want time=4 busy=0", network_time, busy); end
  endtask

  task automatic test_fairness();
    int order[$];
    bit bad;
    hard_reset();
    for (int c = 0; c < NCH; c++) for (int j = 0; j < 20; j++) src_push(c, $urandom_range(0, 16383));
    drive_inputs();
    run_steps = '0; start = 1;
    for (int i = 0; i < 60; i++) begin
      n_vec++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL fair_ready cyc %0d got %b want %b", i, in_ready, exp_ready()); end
      n_vec++; if (!$onehot0(in_ready)) begin n_err++; $display("FAIL fair_onehot cyc %0d got %b want one-hot or zero", i, in_ready); end
      for (int c = 0; c < NCH; c++) if (in_ready[c]) order.push_back(c);
      cycle();
    end
    bad = 0;
    for (int j = 1; j < order.size(); j++) if (order[j] != (order[j-1] + 1) % NCH) bad = 1;
    n_vec++; if (bad || order.size() < 8 || order[0] != 0) begin
      n_err++; $display("FAIL fair_order got %0d grants first=%0d rotation_broken=%0d want rotating from 0", order.size(), order[0], bad);
    end
  endtask

  task automatic test_fifo_full();
    int sent[$];
    int got[$];
    int maxc;
    bit bad;
    hard_reset();
    maxc = 0;
    for (int j = 0; j < 10; j++) begin sent.push_back($urandom_range(0, 16383)); src_push(0, sent[j]); end
    drive_inputs();
    run_steps = '0; start = 1;
    for (int i = 0; i < 100; i++) begin
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (c_accumulate && c_neuron_index == 2'd0 && !c_neuron_we) got.push_back(int'(c_synapse_index));
      n_vec++; if (int'(fifo_count) != m_q.size()) begin n_err++; $display("FAIL full_count cyc %0d got %0d want %0d", i, fifo_count, m_q.size()); end
      n_vec++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL full_ready cyc %0d got %b want %b", i, in_ready, exp_ready()); end
      cycle();
    end
    n_vec++; if (maxc != 8) begin n_err++; $display("FAIL full_saturate got %0d want 8", maxc); end
    bad = (got.size() != 10);
    for (int j = 0; j < got.size() && j < 10; j++) if (got[j] != sent[j]) bad = 1;
    n_vec++; if (bad) begin n_err++; $display("FAIL full_arrival_order got %0d events, order_ok=%0d want 10 in order", got.size(), !bad); end
    stop = 1;
    for (int t = 0; t < 40 && busy; t++) cycle();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_stop_timeout got busy=%0d want 0", busy); end
  endtask

  task automatic test_stop_reset();
    int done_cnt;
    hard_reset();
    done_cnt = 0;
    run_steps = '0; start = 1;
    cycle();
    for (int i = 0; i < 12; i++) begin
      if (i == 1) begin src_push(1, 'h2a1); src_push(3, 'h3b2); drive_inputs(); end
      if (i == 4) stop = 1;
      if (done) done_cnt++;
      n_vec++; if (busy !== m_busy || done !== m_done) begin
        n_err++; $display("FAIL stop_status cyc %0d got busy=%0d done=%0d want busy=%0d done=%0d", i, busy, done, m_busy, m_done);
      end
      cycle();
    end
    n_vec++; if (done_cnt != 1) begin n_err++; $display("FAIL stop_done got %0d pulses want 1", done_cnt); end
    n_vec++; if (fifo_count !== 4'd2) begin n_err++; $display("FAIL stop_fifo_kept got %0d want 2", fifo_count); end
    n_vec++; if (network_time !== 4'd1) begin n_err++; $display("FAIL stop_time got %0d want 1", network_time); end
    start = 1;
    cycle();
    for (int i = 0; i < 11; i++) cycle();
    n_vec++; if (c_accumulate !== 1'b1 || int'(c_synapse_index) != 'h2a1) begin
      n_err++; $display("FAIL stop_resume_acc got acc=%0d syn=%0h want acc=1 syn=2a1", c_accumulate, c_synapse_index);
    end
    reset = 1;
    #1;
    n_vec++; if ({busy, done, c_accumulate, c_neuron_we, c_neuron_index, network_time, fifo_count, c_synapse_index, in_ready} !== '0) begin
      n_err++; $display("FAIL midacc_reset got busy=%0d acc=%0d idx=%0d time=%0d cnt=%0d syn=%0h want all 0",
                        busy, c_accumulate, c_neuron_index, network_time, fifo_count, c_synapse_index);
    end
    hard_reset();
  endtask

  task automatic test_wrap();
    bit saw_wrap;
    int prev;
    hard_reset();
    saw_wrap = 0; prev = 0;
    run_steps = '0; start = 1;
    cycle();
    for (int i = 0; i < 17*2*N + 4; i++) begin
      if (prev == 15 && network_time == 4'd0) saw_wrap = 1;
      prev = int'(network_time);
      n_vec++; if (int'(network_time) != m_time) begin n_err++; $display("FAIL wrap_time cyc %0d got %0d want %0d", i, network_time, m_time); end
      cycle();
    end
    n_vec++; if (!saw_wrap || busy !== 1'b1) begin n_err++; $display("FAIL wrap_seen got wrap=%0d busy=%0d want wrap=1 busy=1", saw_wrap, busy); end
    stop = 1;
    for (int t = 0; t < 40 && busy; t++) cycle();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_stop_timeout got busy=%0d want 0", busy); end
  endtask

  task automatic test_random();
    hard_reset();
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 5) == 0 && (src_tl[c] - src_hd[c]) < 4) src_push(c, $urandom_range(0, 16383));
      drive_inputs();
      if ($urandom_range(0, 9) == 0) begin start = 1; run_steps = TW'($urandom_range(0, 5)); end
      if ($urandom_range(0, 59) == 0) stop = 1;
      n_vec++; if (busy !== m_busy || done !== m_done) begin n_err++; $display("FAIL rnd_status cyc %0d got busy=%0d done=%0d want %0d %0d", i, busy, done, m_busy, m_done); end
      n_vec++; if (c_neuron_we !== exp_we() || int'(c_neuron_index) != exp_index()) begin
        n_err++; $display("FAIL rnd_addr cyc %0d got we=%0d idx=%0d want we=%0d idx=%0d", i, c_neuron_we, c_neuron_index, exp_we(), exp_index());
      end
      n_vec++; if (c_accumulate !== (m_busy && m_acc) || int'(c_synapse_index) != m_syn) begin
        n_err++; $display("FAIL rnd_acc cyc %0d got acc=%0d syn=%0h want acc=%0d syn=%0h", i, c_accumulate, c_synapse_index, m_busy && m_acc, m_syn);
      end
      n_vec++; if (int'(network_time) != m_time) begin n_err++; $display("FAIL rnd_time cyc %0d got %0d want %0d", i, network_time, m_time); end
      n_vec++; if (int'(fifo_count) != m_q.size()) begin n_err++; $display("FAIL rnd_count cyc %0d got %0d want %0d", i, fifo_count, m_q.size()); end
      n_vec++; if (in_ready !== exp_ready()) begin n_err++; $display("FAIL rnd_ready cyc %0d got %b want %b", i, in_ready, exp_ready()); end
      cycle();
    end
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; run_steps = '0;
    in_valid = '0; in_index = '0;
    for (int c = 0; c < NCH; c++) begin src_hd[c] = 0; src_tl[c] = 0; end
    @(posedge clk);
    #1;
    test_reset();
    test_run_length();
    test_accum_order();
    test_fairness();
    test_fifo_full();
    test_stop_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spike_event_scheduler.md
Name: spike_event_scheduler

Overview:
- Parametrised successor to the single-input network controller.
- Sequences time-multiplexed neuron update sweeps and synaptic accumulation sweeps over a neuron SRAM.
- Accepts presynaptic spike events from NUM_CH channels through round-robin arbitration into an event FIFO.
- Adds a bounded run length, a stop request and done/busy status. Sits between spike sources and the neuron updater/accumulator datapath.

Parameters:
- N_NEURONS, 16: neurons per sweep (≥2). Index width NW = $clog2(N_NEURONS).
- SYN_W, 14: synapse (presynaptic) index width.
- NUM_CH, 4: input event channels (≥1).
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2).
- TIME_W, 16: network_time / run_steps width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run (honoured in IDLE only).
- stop  in  1  end the run at the next sweep boundary.
- run_steps  in  TIME_W  update sweeps per run, sampled at start; 0 = free-running.
- in_valid  in  NUM_CH  per-channel event valid.
- in_index  in  NUM_CH*SYN_W  channel k index at bits [k*SYN_W +: SYN_W].
- in_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- c_neuron_index  out  NW  neuron SRAM address.
- c_synapse_index  out  SYN_W  synapse row of the event being accumulated.
- c_neuron_we  out  1  neuron SRAM write enable.
- c_accumulate  out  1  1 = accumulation sweep, 0 = update sweep or idle.
- network_time  out  TIME_W  completed update sweeps in the current run.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued events.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a run ends.

Behaviour:
- Reset values: every output 0; FIFO emptied; arbiter priority set to channel 0; stop latch cleared; state IDLE.
- Reset mid-run aborts immediately. done does not pulse on reset.
- States: IDLE, UPDATE, ACCUM.
- Control decode from registers:
  - c_neuron_we = busy & phase
  - c_neuron_index = idx
  - c_accumulate = (state == ACCUM)
- Sweep timing:
  - Each neuron takes 2 cycles: phase 0 reads, phase 1 writes.
  - idx advances 0..N_NEURONS-1 after each phase 1, so one sweep = 2*N_NEURONS cycles.
  - The boundary is the cycle with idx = N_NEURONS-1 and phase = 1.
- IDLE:
  - start clears network_time, latches run_steps, enters UPDATE with idx = 0, phase = 0.
  - start while busy is ignored.
- UPDATE boundary:
  - network_time increments, wrapping at 2^TIME_W.
  - If the new value equals the latched run_steps (run_steps ≠ 0), or stop is latched: go to IDLE and pulse done the next cycle.
  - Else if FIFO is non-empty: pop the head into c_synapse_index, go to ACCUM.
  - Else: start another UPDATE sweep.
- ACCUM boundary:
  - If stop is latched: go to IDLE and pulse done.
  - Else if FIFO is non-empty: pop the next event and run another ACCUM.
  - Else: go to UPDATE.
  - All queued events are drained before the next update sweep.
- stop: a cycle-level request latched while busy, cleared on entering IDLE. stop in IDLE has no effect. FIFO contents survive the stop.
- Arbiter:
  - Each cycle, in any state, grant the first channel with in_valid set, searching from the priority pointer upward (mod NUM_CH).
  - Grant only when fifo_count < FIFO_DEPTH, evaluated on the registered count; a same-cycle pop does not free space.
  - The granted channel's in_ready = 1 (combinational), and its index is pushed at the clock edge.
  - After a grant to channel k, priority becomes k+1 mod NUM_CH.
  - A source holds in_valid/in_index until in_ready.
- FIFO:
  - Push and pop in the same cycle leave the count unchanged and preserve order.
  - Pop only at boundaries; never pops when empty.
  - Full: all in_ready = 0, no data lost.
- An event accepted during an UPDATE sweep is accumulated in the ACCUM sweep that immediately follows that sweep.

Test Plan:
- Run length, N_NEURONS=4, run_steps=3, no events: start → busy 24 cycles, c_neuron_we toggles 0,1 each cycle, c_neuron_index 0,0,1,1,2,2,3,3; network_time steps 1,2,3; done is a single pulse; busy = 0 afterwards.
- Accumulation ordering: push one event, index 0x155, on ch2 during UPDATE sweep 1 → next 8 cycles c_accumulate = 1, c_synapse_index = 0x155; then UPDATE resumes; network_time is not incremented by ACCUM.
- Arbitration fairness: all 4 channels valid continuously, FIFO draining → grants in order 0,1,2,3,0,…; each in_ready is one-hot.
- FIFO full: run_steps=0, 10 back-to-back events on ch0 during one sweep → fifo_count saturates at 8; in_ready[0] = 0 until the first pop; accumulation indices are in arrival order; no event is lost.
- Stop and reset: stop pulsed mid-sweep with 2 events queued → run ends at the current sweep boundary; done pulses; fifo_count stays 2. Reset mid-ACCUM → all outputs 0 and fifo_count = 0 immediately.
- Free-run wrap: TIME_W=4, run_steps=0 → network_time counts 15 → 0 and continues until stop.
